// File: rtl/wb_sched.sv
// wb_sched: write-back scheduler and register scoreboard.
// Three producers (ALU, MEM, FPU) share one register-file write port through a
// round-robin arbiter. Pending bits per register class flag ID-stage RAW
// hazards and stall issue on WAW.
// Build option WB_ALU_PRIO_EN: ALU gets fixed top priority, and MEM/FPU
// round-robin between themselves only.
//
// Arbitration pointer (default build):
//   ptr | meaning
//   0   | ALU checked first
//   1   | MEM checked first
//   2   | FPU checked first
module wb_sched #(
  parameter int XLEN = 32,
  parameter int RAW  = 5
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            alu_valid,
  input  logic [RAW-1:0]  alu_rd,
  input  logic [1:0]      alu_cls,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            mem_valid,
  input  logic [RAW-1:0]  mem_rd,
  input  logic [1:0]      mem_cls,
  input  logic [XLEN-1:0] mem_data,
  output logic            mem_ready,
  input  logic            fpu_valid,
  input  logic [RAW-1:0]  fpu_rd,
  input  logic [1:0]      fpu_cls,
  input  logic [XLEN-1:0] fpu_data,
  output logic            fpu_ready,
  input  logic            iss_valid,
  input  logic [RAW-1:0]  iss_rd,
  input  logic [1:0]      iss_cls,
  output logic            iss_stall,
  input  logic [RAW-1:0]  rs1_id,
  input  logic [RAW-1:0]  rs2_id,
  input  logic            rs1_fpu_id,
  input  logic            rs2_fpu_id,
  output logic            hazard_id,
  output logic [RAW-1:0]  rd_wb,
  output logic [1:0]      regwrite_wb,
  output logic [XLEN-1:0] write_data_register_wb
);

  localparam int NREG = 1 << RAW;
  localparam logic [1:0] CLS_INT = 2'b01;
  localparam logic [1:0] CLS_FP  = 2'b10;

  logic [NREG-1:0] pend_int, pend_fp;
  logic [NREG-1:0] pend_int_nxt, pend_fp_nxt;
  logic [2:0]      gnt;
  logic            xfer;
  logic [RAW-1:0]  sel_rd;
  logic [1:0]      sel_cls;
  logic [XLEN-1:0] sel_data;
  logic [1:0]      sel_we;
  logic            iss_pend;
  logic            iss_set;

`ifdef WB_ALU_PRIO_EN
  logic ptr_fpu;  // 0: MEM checked first, 1: FPU checked first

  // ALU wins outright; MEM and FPU alternate when ALU is idle
  always_comb begin
    gnt = 3'b000;
    if (alu_valid)                 gnt = 3'b001;
    else if (ptr_fpu && fpu_valid) gnt = 3'b100;
    else if (mem_valid)            gnt = 3'b010;
    else if (fpu_valid)            gnt = 3'b100;
  end

  // pointer only moves on MEM/FPU grants
  always_ff @(posedge clk) begin
    if (!rstn)       ptr_fpu <= 1'b0;
    else if (gnt[1]) ptr_fpu <= 1'b1;
    else if (gnt[2]) ptr_fpu <= 1'b0;
  end
`else
  logic [1:0] ptr;

  // 3-way round robin starting at the pointer
  always_comb begin
    gnt = 3'b000;
    case (ptr)
      2'd1: begin
        if (mem_valid)      gnt = 3'b010;
        else if (fpu_valid) gnt = 3'b100;
        else if (alu_valid) gnt = 3'b001;
      end
      2'd2: begin
        if (fpu_valid)      gnt = 3'b100;
        else if (alu_valid) gnt = 3'b001;
        else if (mem_valid) gnt = 3'b010;
      end
      default: begin
        if (alu_valid)      gnt = 3'b001;
        else if (mem_valid) gnt = 3'b010;
        else if (fpu_valid) gnt = 3'b100;
      end
    endcase
  end

  // pointer moves to the source after the granted one
  always_ff @(posedge clk) begin
    if (!rstn)       ptr <= 2'd0;
    else if (gnt[0]) ptr <= 2'd1;
    else if (gnt[1]) ptr <= 2'd2;
    else if (gnt[2]) ptr <= 2'd0;
  end
`endif

  assign alu_ready = gnt[0];
  assign mem_ready = gnt[1];
  assign fpu_ready = gnt[2];
  assign xfer      = |gnt;

  // mux the granted producer and decide whether the register file really writes
  always_comb begin
    sel_rd   = alu_rd;
    sel_cls  = alu_cls;
    sel_data = alu_data;
    if (gnt[1]) begin
      sel_rd   = mem_rd;
      sel_cls  = mem_cls;
      sel_data = mem_data;
    end else if (gnt[2]) begin
      sel_rd   = fpu_rd;
      sel_cls  = fpu_cls;
      sel_data = fpu_data;
    end
    sel_we = 2'b00;
    if (sel_cls == CLS_INT && sel_rd != '0)     sel_we = CLS_INT;
    else if (sel_cls == CLS_FP && sel_rd != '1) sel_we = CLS_FP;
  end

  assign iss_pend  = (iss_cls == CLS_INT && pend_int[iss_rd]) ||
                     (iss_cls == CLS_FP  && pend_fp[iss_rd]);
  assign iss_stall = iss_valid && iss_pend;
  // x0 and f31 are hardwired zero, so they are never tracked
  assign iss_set   = iss_valid && !iss_pend &&
                     ((iss_cls == CLS_INT && iss_rd != '0) ||
                      (iss_cls == CLS_FP  && iss_rd != '1));

  assign hazard_id = (rs1_fpu_id ? pend_fp[rs1_id] : pend_int[rs1_id]) ||
                     (rs2_fpu_id ? pend_fp[rs2_id] : pend_int[rs2_id]);

  // scoreboard next state: clear the granted target, then set the issued one
  always_comb begin
    pend_int_nxt = pend_int;
    pend_fp_nxt  = pend_fp;
    if (xfer && sel_cls == CLS_INT) pend_int_nxt[sel_rd] = 1'b0;
    if (xfer && sel_cls == CLS_FP)  pend_fp_nxt[sel_rd]  = 1'b0;
    if (iss_set && iss_cls == CLS_INT) pend_int_nxt[iss_rd] = 1'b1;
    if (iss_set && iss_cls == CLS_FP)  pend_fp_nxt[iss_rd]  = 1'b1;
  end

  // scoreboard and registered write-back port
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pend_int               <= '0;
      pend_fp                <= '0;
      rd_wb                  <= '0;
      regwrite_wb            <= 2'b00;
      write_data_register_wb <= '0;
    end else begin
      pend_int    <= pend_int_nxt;
      pend_fp     <= pend_fp_nxt;
      regwrite_wb <= xfer ? sel_we : 2'b00;
      if (xfer) begin
        rd_wb                  <= sel_rd;
        write_data_register_wb <= sel_data;
      end
    end
  end

endmodule
